// File: rtl/lab2_q4_pkg.sv
// Shared definitions for the lab2 q4 sequencer: the controller state
// encoding, the bit positions used on the bidirectional uio bus, and the
// constant output-enable pattern driven on uio_oe.
package lab2_q4_pkg;

  // Controller states: wait for A, wait for B, compute, hold result
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit positions on uio_in (handshake inputs)
  localparam int UIO_VALID = 0;
  localparam int UIO_ACK   = 1;

  // Bit positions on uio_out (status outputs)
  localparam int UIO_READY = 4;
  localparam int UIO_DONE  = 5;
  localparam int UIO_BUSY  = 6;
  localparam int UIO_ERR   = 7;

  // Upper nibble of uio is output, lower nibble is input
  localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/lab2_q4_alu.sv
// Combinational datapath for the lab2 q4 sequencer.
// The low seven bits are a bitwise AND of the operands. The top bit keeps
// A's sign when both signs agree and inverts it when they disagree.
module lab2_q4_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  // Build the result from the masked AND and the sign-agreement rule
  always_comb begin
    y[6:0] = a[6:0] & b[6:0];
    y[7]   = (a[7] == b[7]) ? a[7] : ~a[7];
  end

endmodule

// File: rtl/tt_um_lab2_q4_seq.sv
// Two-operand sequencer: accepts operand A, then operand B, computes one
// result through lab2_q4_alu, and holds it on uo_out until overwritten.
// WAIT_B is guarded by an idle timer that drops back to IDLE with a sticky
// error flag when B does not arrive in time.
// Optional build macro: LAB2_Q4_AUTOACK_EN -- when defined, DONE lasts a
// single cycle and ack is ignored; otherwise DONE waits for ack.
module tt_um_lab2_q4_seq
  import lab2_q4_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Last timer value before a timeout fires
  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  opA_q, opA_d;
  logic [7:0]  opB_q, opB_d;
  logic [3:0]  timer_q, timer_d;
  logic [7:0]  result_q, result_d;
  logic        err_q, err_d;

  logic        validIn;
  logic        ackIn;
  logic        readyOut;
  logic [7:0]  aluY;
  logic        unusedBits;

  assign validIn  = uio_in[UIO_VALID];
  assign ackIn    = uio_in[UIO_ACK];
  assign readyOut = (state_q == IDLE) || (state_q == WAIT_B);

`ifdef LAB2_Q4_AUTOACK_EN
  assign unusedBits = &{1'b0, uio_in[7:2], ackIn};
`else
  assign unusedBits = &{1'b0, uio_in[7:2]};
`endif

  lab2_q4_alu uAlu (
    .a (opA_q),
    .b (opB_q),
    .y (aluY)
  );

  // State and datapath registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      timer_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update; everything holds while ena is low
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    timer_d  = timer_q;
    result_d = result_q;
    err_d    = err_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (validIn) begin
            opA_d   = ui_in;
            err_d   = 1'b0;
            timer_d = '0;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (validIn) begin
            opB_d   = ui_in;
            state_d = EXEC;
          end else if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        EXEC: begin
          result_d = aluY;
          state_d  = DONE;
        end
        DONE: begin
`ifdef LAB2_Q4_AUTOACK_EN
          state_d = IDLE;
`else
          if (ackIn) begin
            state_d = IDLE;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state and sticky error
  always_comb begin
    uio_out            = '0;
    uio_out[UIO_READY] = readyOut;
    uio_out[UIO_DONE]  = (state_q == DONE);
    uio_out[UIO_BUSY]  = (state_q == EXEC);
    uio_out[UIO_ERR]   = err_q;
  end

  assign uo_out = result_q;
  assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_tt_um_lab2_q4_seq.sv
// Self-checking bench for tt_um_lab2_q4_seq: directed scenarios with
// literal expectations, then randomized traffic checked every cycle
// against a transaction-level model of the sequencer.
module tb_tt_um_lab2_q4_seq;

  localparam int TMO = 7;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;
  bit checkOn;

  // Model of the sequencer: which phase the operation is in, the operands,
  // the held result, the sticky error and the idle cycles seen waiting for B
  int         mPhase;
  logic [7:0] mA;
  logic [7:0] mB;
  logic [7:0] mUo;
  bit         mErr;
  int         mIdleSeen;

  tt_um_lab2_q4_seq #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result rule written arithmetically: low seven bits are the AND of the
  // low seven bits; top bit keeps A's sign on agreement, flips it otherwise
  function automatic logic [7:0] expectedResult(input logic [7:0] a, input logic [7:0] b);
    int signA;
    int signB;
    int top;
    int low;
    signA = int'(a) / 128;
    signB = int'(b) / 128;
    top   = (signA == signB) ? signA : (1 - signA);
    low   = int'(a & b) % 128;
    return 8'(top * 128 + low);
  endfunction

  // Expected status byte given the model phase and error flag
  function automatic logic [7:0] expectedStatus(input int phase, input bit errFlag);
    logic [7:0] s;
    s = 8'h00;
    if (phase == 0 || phase == 1) s = s | 8'h10;
    if (phase == 3)               s = s | 8'h20;
    if (phase == 2)               s = s | 8'h40;
    if (errFlag)                  s = s | 8'h80;
    return s;
  endfunction

  // Advance the model on each clock edge; reset clears it at once
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase    <= 0;
      mA        <= 8'h00;
      mB        <= 8'h00;
      mUo       <= 8'h00;
      mErr      <= 1'b0;
      mIdleSeen <= 0;
    end else if (ena) begin
      case (mPhase)
        0: begin
          if (uio_in[0]) begin
            mA        <= ui_in;
            mErr      <= 1'b0;
            mIdleSeen <= 0;
            mPhase    <= 1;
          end
        end
        1: begin
          if (uio_in[0]) begin
            mB     <= ui_in;
            mPhase <= 2;
          end else if (mIdleSeen + 1 >= TMO) begin
            mErr   <= 1'b1;
            mPhase <= 0;
          end else begin
            mIdleSeen <= mIdleSeen + 1;
          end
        end
        2: begin
          mUo    <= expectedResult(mA, mB);
          mPhase <= 3;
        end
        3: begin
`ifdef LAB2_Q4_AUTOACK_EN
          mPhase <= 0;
`else
          if (uio_in[1]) mPhase <= 0;
`endif
        end
        default: mPhase <= 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%02h expected=%02h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle past it
  task automatic applyStimulus(input logic rstVal, input logic enVal, input logic validVal,
                               input logic ackVal, input logic [7:0] dataVal);
    rst_n  = rstVal;
    ena    = enVal;
    ui_in  = dataVal;
    uio_in = {6'b0, ackVal, validVal};
    @(posedge clk);
    #1;
  endtask

  // Leave DONE: ack in the handshake build, a plain cycle in the auto build
  task automatic completeOp();
`ifdef LAB2_Q4_AUTOACK_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
`else
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
`endif
    checkOutput("leaveDone.status", uio_out, 8'h10);
  endtask

  // Compare DUT against the model on every cycle once checking is armed
  always @(posedge clk) begin
    #1;
    if (checkOn) begin
      checkOutput("model.uo_out", uo_out, mUo);
      checkOutput("model.uio_out", uio_out, expectedStatus(mPhase, mErr));
      checkOutput("model.uio_oe", uio_oe, 8'hF0);
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    checkOn  = 1'b0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    #1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);

    checkOutput("reset.uo_out", uo_out, 8'h00);
    checkOutput("reset.status", uio_out, 8'h10);
    checkOutput("reset.oe", uio_oe, 8'hF0);
    checkOn = 1'b1;

    // A=F3, B=5A: busy after the B edge, done one cycle later, result 52
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hF3);
    checkOutput("opA.status", uio_out, 8'h10);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A);
    checkOutput("opB.busy", uio_out, 8'h40);
    checkOutput("opB.uoHeld", uo_out, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("exec.done", uio_out, 8'h20);
    checkOutput("exec.result52", uo_out, 8'h52);
    completeOp();

    // A=8F, B=FF: result 8F; DONE holds without ack and ignores valid
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h8F);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("op2.result8F", uo_out, 8'h8F);
    checkOutput("op2.done", uio_out, 8'h20);
`ifndef LAB2_Q4_AUTOACK_EN
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C);
      checkOutput("op2.doneHold", uio_out, 8'h20);
    end
    checkOutput("op2.resultKept", uo_out, 8'h8F);
`endif
    completeOp();

    // Timeout: A accepted, then TMO idle cycles -> IDLE with err
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h11);
    for (int i = 0; i < TMO - 1; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("tmo.waiting", uio_out, 8'h10);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("tmo.errSet", uio_out, 8'h90);
    checkOutput("tmo.uoKept", uo_out, 8'h8F);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h22);
    checkOutput("tmo.errCleared", uio_out, 8'h10);

    // B arrives on the final timeout cycle: EXEC wins, err stays clear
    for (int i = 0; i < TMO - 1; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
    checkOutput("lastCycleB.busy", uio_out, 8'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("lastCycleB.result", uo_out, 8'h22);
    completeOp();

    // Reset during EXEC: result forced to 0, no done afterwards
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hF0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h0F);
    checkOutput("rstExec.busy", uio_out, 8'h40);
    rst_n = 1'b0;
    #1;
    checkOutput("rstExec.uoCleared", uo_out, 8'h00);
    checkOutput("rstExec.status", uio_out, 8'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("rstExec.noDone", uio_out, 8'h10);
    end

    // ena low for 20 cycles in WAIT_B: no timeout, no capture
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h5C);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 3) == 0, 1'b1, 8'hEE);
      checkOutput("enaLow.hold", uio_out, 8'h10);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3);
    checkOutput("enaLow.busyAfter", uio_out, 8'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("enaLow.resultC0", uo_out, 8'hC0);
    completeOp();

    // Randomized traffic; valid density alternates to provoke timeouts
    for (int blk = 0; blk < 15; blk++) begin
      int validPct;
      validPct = (blk % 2 == 0) ? 55 : 8;
      for (int i = 0; i < 200; i++) begin
        logic rv;
        logic ev;
        logic vv;
        logic av;
        rv = ($urandom_range(0, 249) != 0);
        ev = ($urandom_range(0, 99) < 85);
        vv = ($urandom_range(0, 99) < validPct);
        av = ($urandom_range(0, 99) < 30);
        applyStimulus(rv, ev, vv, av, 8'($urandom_range(0, 255)));
      end
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
